sr_latch_sequencer: RTL and testbench

//  Clocked controller that shares one NAND SR latch (active-low S_n/R_n) between N_REQ requesters.

---
 rtl/sr_latch_sequencer.sv | 159 +++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_sequencer.sv
// sr_latch_sequencer
//   Shares one NAND SR latch (active-low s_n/r_n) between N_REQ requesters.
//   Requests are arbitrated round-robin. Each accepted operation drives one
//   timed low pulse on s_n (set) or r_n (clear), then a gap with both inputs
//   high, then a done pulse. s_n and r_n are never low together.
//
//   Ports:
//     clk, rst     rising-edge clock, asynchronous active-high reset
//     req[N_REQ]   level requests, held by each requester until its done
//     op[N_REQ]    1 = set, 0 = clear; sampled when the request is granted
//     gnt[N_REQ]   one-hot, one-cycle pulse: request accepted
//     done[N_REQ]  one-hot, one-cycle pulse: operation complete
//     busy         high while an operation is in flight (PULSE/GAP/DONE)
//     s_n, r_n     latch set/reset inputs, active low
//     q_fb         latch Q feedback (read-back check only)
//     err_clr      clears the sticky err flag
//     err          sticky read-back mismatch flag
//
//   Optional feature: define SR_VERIFY_EN to compare q_fb with the granted op
//   on entry to DONE. Without it, err is tied low and q_fb/err_clr are ignored.
module sr_latch_sequencer #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned GAP_CYC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] op,
   output logic [N_REQ-1:0] gnt,
   output logic [N_REQ-1:0] done,
   output logic             busy,
   output logic             s_n,
   output logic             r_n,
   input  logic             q_fb,
   input  logic             err_clr,
   output logic             err
);

   localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] idx_l;
   logic [CNT_W-1:0] cnt;

   logic             pick_valid_c;
   logic [IDX_W-1:0] pick_idx_c;
   logic [IDX_W-1:0] cand_c;

   // Round-robin pick: first asserted request at or above ptr, wrapping.
   always_comb begin
      pick_valid_c = 1'b0;
      pick_idx_c   = '0;
      cand_c       = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand_c = IDX_W'((32'(ptr) + k) % N_REQ);
         if (!pick_valid_c && req[cand_c]) begin
            pick_valid_c = 1'b1;
            pick_idx_c   = cand_c;
         end
      end
   end

   // Sequencer: grant, pulse, gap, done. Reset releases both latch inputs at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         idx_l <= '0;
         cnt   <= '0;
         gnt   <= '0;
         done  <= '0;
         busy  <= 1'b0;
         s_n   <= 1'b1;
         r_n   <= 1'b1;
      end else begin
         gnt  <= '0;
         done <= '0;
         unique case (state)
            IDLE: begin
               if (pick_valid_c) begin
                  gnt   <= ONE_HOT0 << pick_idx_c;
                  idx_l <= pick_idx_c;
                  s_n   <= ~op[pick_idx_c];
                  r_n   <= op[pick_idx_c];
                  cnt   <= CNT_W'(PULSE_CYC - 1);
                  busy  <= 1'b1;
                  state <= PULSE;
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  s_n   <= 1'b1;
                  r_n   <= 1'b1;
                  cnt   <= CNT_W'(GAP_CYC - 1);
                  state <= GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  done  <= ONE_HOT0 << idx_l;
                  state <= DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               // req is deliberately not sampled here; arbitration resumes next cycle.
               ptr   <= (idx_l == IDX_W'(N_REQ - 1)) ? '0 : idx_l + IDX_W'(1);
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SR_VERIFY_EN
   logic op_l;

   // Op captured at grant; later changes to op are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_l <= 1'b0;
      end else if (state == IDLE && pick_valid_c) begin
         op_l <= op[pick_idx_c];
      end
   end

   // Sticky read-back check on entry to DONE; a mismatch outranks err_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (state == GAP && cnt == '0 && q_fb != op_l) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end
`else
   logic unused_verify;
   assign unused_verify = ^{q_fb, err_clr};
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// tb_sr_latch_sequencer
//   Drives directed and random request traffic into sr_latch_sequencer and
//   compares every output each cycle against a timeline model: an operation
//   is tracked only as "cycles since grant", from which gnt, pulse, gap, done
//   and busy follow directly. A behavioural NAND latch closes the q_fb loop.
module tb_sr_latch_sequencer;

   localparam int N = 4;
   localparam int P = 2;
   localparam int G = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] op  = '0;
   logic [N-1:0] gnt;
   logic [N-1:0] done;
   logic         busy;
   logic         s_n;
   logic         r_n;
   logic         q_fb;
   logic         err_clr = 1'b0;
   logic         err;

   logic         q_latch = 1'b0;
   logic         bad_fb  = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit m_active = 0;
   int m_t      = 0;
   int m_idx    = 0;
   bit m_op     = 0;
   int m_ptr    = 0;
   bit m_err    = 0;

   always #5 clk = ~clk;

   // Behavioural latch driven by the DUT; q_fb can be forced wrong.
   always @(s_n or r_n) begin
      if (!s_n) q_latch = 1'b1;
      else if (!r_n) q_latch = 1'b0;
   end
   assign q_fb = bad_fb ? ~q_latch : q_latch;

   sr_latch_sequencer #(.N_REQ(N), .PULSE_CYC(P), .GAP_CYC(G)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .op      (op),
      .gnt     (gnt),
      .done    (done),
      .busy    (busy),
      .s_n     (s_n),
      .r_n     (r_n),
      .q_fb    (q_fb),
      .err_clr (err_clr),
      .err     (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_t      = 0;
      m_idx    = 0;
      m_op     = 0;
      m_ptr    = 0;
      m_err    = 0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge(input logic [N-1:0] req_s, input logic [N-1:0] op_s,
                             input logic qfb_s, input logic clr_s);
      bit mismatch = 0;
      if (m_active) begin
         m_t++;
         if (m_t == P + G + 1) begin
            m_active = 0;
            m_ptr    = (m_idx + 1) % N;
         end else if (m_t == P + G) begin
            mismatch = (qfb_s != m_op);
         end
      end else if (req_s != '0) begin
         for (int k = 0; k < N; k++) begin
            int c = (m_ptr + k) % N;
            if (!m_active && req_s[c]) begin
               m_active = 1;
               m_t      = 0;
               m_idx    = c;
               m_op     = op_s[c];
            end
         end
      end
`ifdef SR_VERIFY_EN
      if (mismatch) m_err = 1;
      else if (clr_s) m_err = 0;
`else
      if (mismatch && clr_s) m_err = 0;
`endif
   endtask

   task automatic check_all();
      logic [N-1:0] oh;
      logic         pulsing;
      oh      = N'(1) << m_idx;
      pulsing = m_active && (m_t < P);
      check("gnt",  32'(gnt),  32'((m_active && m_t == 0) ? oh : '0));
      check("done", 32'(done), 32'((m_active && m_t == P + G) ? oh : '0));
      check("s_n",  32'(s_n),  32'(!(pulsing && m_op)));
      check("r_n",  32'(r_n),  32'(!(pulsing && !m_op)));
      check("busy", 32'(busy), 32'(m_active));
      check("err",  32'(err),  32'(m_err));
      check("no_forbidden", 32'(!s_n && !r_n), 32'(0));
   endtask

   task automatic step();
      logic [N-1:0] req_s, op_s;
      logic         qfb_s, clr_s;
      req_s = req;
      op_s  = op;
      qfb_s = q_fb;
      clr_s = err_clr;
      @(posedge clk);
      model_edge(req_s, op_s, qfb_s, clr_s);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [N-1:0] gnt_seen[$];
   logic [N-1:0] exp_order[5];

   initial begin
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset and idle
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Single set from requester 0
      req = 4'b0001;
      op  = 4'b0001;
      for (int i = 0; i < 4; i++) step();
      req = 4'b0000;
      check("q_after_set", 32'(q_latch), 32'(1));
      for (int i = 0; i < 3; i++) step();

      // All requesters held: strict rotation, alternating clear/set
      do_reset();
      req = 4'b1111;
      op  = 4'b1010;
      for (int i = 0; i < 21; i++) begin
         step();
         if (gnt != '0) gnt_seen.push_back(gnt);
      end
      check("rotation_count", 32'(gnt_seen.size()), 32'(5));
      for (int i = 0; i < 5; i++) begin
         if (i < gnt_seen.size()) check("rotation_order", 32'(gnt_seen[i]), 32'(exp_order[i]));
      end

      // Reset mid-pulse: latch released immediately, pointer back to 0
      do_reset();
      req = 4'b0010;
      op  = 4'b0010;
      step();
      check("pulse_started", 32'(s_n), 32'(0));
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_s_n", 32'(s_n), 32'(1));
      check("async_busy", 32'(busy), 32'(0));
      check_all();
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111;
      op  = 4'b0000;
      step();
      check("post_reset_gnt", 32'(gnt), 32'(4'b0001));
      req = 4'b0000;
      for (int i = 0; i < 5; i++) step();

`ifdef SR_VERIFY_EN
      // Read-back mismatch sets sticky err; err_clr clears it
      do_reset();
      bad_fb = 1'b1;
      req    = 4'b0001;
      op     = 4'b0001;
      for (int i = 0; i < 4; i++) step();
      req = 4'b0000;
      for (int i = 0; i < 3; i++) step();
      bad_fb = 1'b0;
      check("err_sticky", 32'(err), 32'(1));
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("err_cleared", 32'(err), 32'(0));
`endif

      // Random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
         op      = N'($urandom_range(0, 15));
         err_clr = ($urandom_range(0, 15) == 0);
`ifdef SR_VERIFY_EN
         bad_fb  = ($urandom_range(0, 7) == 0);
`endif
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
